uart_rx_fsm: RTL
================

Name: uart_rx_fsm

Overview:
RS-232 receive front end of the serial-to-parallel path. Synchronises the asynchronous rx line, detects the start bit and samples each data bit at mid-bit using a clock-count baud timer. Assembles the bits LSB-first and presents the word on dout_o with a one-cycle done_o strobe. done_o drives the enable of the downstream parallel-in/parallel-out holding register.

Parameters:
Width, 8, number of data bits per frame (5..9)
BaudDiv, 5208, clk_i cycles per bit (50 MHz / 9600 baud); must be >= 4 and even

Ports:
clk_i  in  1  system clock, rising edge
rst_i  in  1  asynchronous active-low reset
rx_i  in  1  serial line, idle high, asynchronous to clk_i
dout_o  out  Width  received word, LSB = first data bit received
done_o  out  1  one-cycle pulse: valid frame received, dout_o updated this cycle
frame_err_o  out  1  one-cycle pulse: stop bit sampled low
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_i = 0, asynchronous): state IDLE; dout_o = 0, done_o = 0, frame_err_o = 0, busy_o = 0; bit counter = 0, baud counter = 0; both synchroniser flops = 1.
- rx_i passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only. This adds 2 cycles of latency.
- Baud counter cnt: cleared on every state entry, increments each cycle, width clog2(BaudDiv).
- IDLE: when rx_s = 0, go to START.
- START: when cnt = BaudDiv/2 - 1, re-sample rx_s. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no pulse.
- DATA: when cnt = BaudDiv - 1, shift rx_s into the MSB of the shift register (right shift) and increment bit_idx. After Width samples, go to STOP.
- STOP: when cnt = BaudDiv - 1, sample rx_s.
  - If 1: load dout_o from the shift register, pulse done_o for 1 cycle, go to IDLE.
  - If 0: pulse frame_err_o for 1 cycle, leave dout_o unchanged, go to BREAK.
- BREAK: wait for rx_s = 1, then go to IDLE. This prevents a held-low line (break) from retriggering a start.
- Latency: from the rx_i falling edge to done_o high is 2 + BaudDiv/2 + Width*BaudDiv + BaudDiv + 1 cycles (±1 for edge alignment). Each sample point is at bit centre.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit. A start edge half a bit later is detected with no lost frame.
- done_o and frame_err_o are mutually exclusive and never high for more than 1 cycle.
- dout_o holds its value between frames. The shift register contents are not visible until done_o.
- Reset mid-frame aborts immediately. No done_o or frame_err_o is emitted for the partial frame.
- Unused state encodings recover to IDLE.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP, BREAK} as a 3-bit localparam set
  - helper constant HALF_DIV = BaudDiv/2
- Sub-module sync_2ff (1-bit 2-flop synchroniser, async active-low reset to 1). It is reused by the future tx/cts paths.
- FSM, counters and shift register stay in uart_rx_fsm.

Test Plan:
(All tests use BaudDiv = 16, Width = 8; bit period = 16 cycles.)
1. Single frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> dout_o = 0xA5, exactly one done_o pulse 2+8+128+16+1 = 155 ±1 cycles after the falling edge; frame_err_o stays 0.
2. Glitch: rx_i low for 4 cycles then high -> FSM returns to IDLE, busy_o deasserts; no done_o, no frame_err_o; dout_o unchanged.
3. Framing error: frame 0x3C with stop bit 0, then line held low for 40 cycles, then high -> one frame_err_o pulse, dout_o keeps its prior value, busy_o stays high until the line returns high, no spurious start.
4. Back-to-back: 0x00 immediately followed by 0xFF, one stop bit each -> two done_o pulses 160 ±1 cycles apart, dout_o = 0x00 then 0xFF.
5. Reset mid-frame: assert rst_i low during bit 3 of frame 0x55 for 3 cycles, release, then send 0x81 -> all outputs 0 during reset, only one done_o pulse with dout_o = 0x81.
6. Width = 7, frame 0x7F -> dout_o = 7'h7F, done_o pulse at the 7-bit latency (139 ±1 cycles).

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART receive and transmit paths.
// Holds the receiver state encodings and the baud-divider helpers.
package uart_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    localparam int BAUD_DIV_DEF = 5208;
    localparam int HALF_DIV     = BAUD_DIV_DEF / 2;

    function automatic int half_div(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous input.
// Resets to 1 so an idle-high serial line never looks like a start bit.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive front end, mid-bit sampling, LSB first.
// Presents each good word on dout_o with a one-cycle done_o strobe.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int Width   = 8,
    parameter int BaudDiv = BAUD_DIV_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_i,
    output logic [Width-1:0] dout_o,
    output logic             done_o,
    output logic             frame_err_o,
    output logic             busy_o
);

    localparam int CntW = $clog2(BaudDiv);
    localparam int IdxW = $clog2(Width + 1);

    localparam logic [CntW-1:0] MidCnt  = CntW'(half_div(BaudDiv) - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(BaudDiv - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Width - 1);

    logic             rx_s;
    logic [2:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [IdxW-1:0]  bit_idx_q, bit_idx_d;
    logic [Width-1:0] shift_q, shift_d;
    logic [Width-1:0] dout_q, dout_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;

    sync_2ff u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    // Frame sequencing: start check, data shifting, stop check
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == MidCnt) begin
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == LastCnt) begin
                    shift_d = {rx_s, shift_q[Width-1:1]};
                    if (bit_idx_q == LastIdx) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end
            end
            STOP: begin
                if (cnt_q == LastCnt) begin
                    if (rx_s) begin
                        dout_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Baud counter: restarts on state entry and at each bit boundary
    always_comb begin
        if ((state_d != state_q) || (cnt_q == LastCnt)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // State, counters, data and strobes
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign dout_o      = dout_q;
    assign done_o      = done_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = (state_q != IDLE);

endmodule
